inst_mem_loader: RTL and testbench

- Byte-stream program loader that acts as the writer for the instruction memory's write port (OP_Code / Write_Address / Write_Enable).
- Receives a framed byte stream from the host or debug link, assembles 16-bit instruction words, and writes them to consecutive word addresses.
- Verifies a checksum at the end of the frame.
- Asserts Busy so the top level can hold the pipeline while the program image is loaded.

---
 rtl/inst_mem_loader_pkg.sv | 18 +
 rtl/inst_mem_loader.sv | 117 +++++++++++
 tb/tb_inst_mem_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_pkg.sv
// Shared types and frame constants for the byte-stream instruction memory loader.
package inst_mem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_CNT,
    S_DLO,
    S_DHI,
    S_WSTB,
    S_CHK
  } ld_state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         BASE_BYTES    = 4;
  localparam int         CNT_BYTES     = 2;

endpackage

// File: rtl/inst_mem_loader.sv
// Framed byte-stream loader: SYNC, BASE[4], COUNT[2], DATA[2N], CHK -> 16-bit memory writes.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         ADDR_W    = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [7:0]        In_Data,
  input  logic              In_Valid,
  output logic              In_Ready,
  output logic [15:0]       OP_Code,
  output logic [ADDR_W-1:0] Write_Address,
  output logic              Write_Enable,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  localparam logic [1:0] BASE_LAST = 2'(BASE_BYTES - 1);
  localparam logic [1:0] CNT_LAST  = 2'(CNT_BYTES - 1);

  ld_state_e         state_q;
  logic [31:0]       base_q;
  logic [15:0]       n_q, idx_q;
  logic [1:0]        bcnt_q;
  logic [7:0]        lo_q, chk_q;
  logic [15:0]       op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q, busy_q, done_q, err_q;
  logic              acc;
  logic [15:0]       n_d;

  assign In_Ready = (state_q != S_WSTB);
  assign acc      = In_Valid & In_Ready;
  assign n_d      = {In_Data, n_q[15:8]};

  // Strobe lags the WSTB state by one cycle so address/data settle a full
  // cycle before the level-sensitive write port sees Write_Enable.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      lo_q    <= '0;
      chk_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= (state_q == S_WSTB);
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (acc && In_Data == SYNC_BYTE) begin
          state_q <= S_BASE;
          busy_q  <= 1'b1;
          err_q   <= 1'b0;
          bcnt_q  <= '0;
          chk_q   <= '0;
          idx_q   <= '0;
        end
        S_BASE: if (acc) begin
          base_q <= {In_Data, base_q[31:8]};
          bcnt_q <= bcnt_q + 2'd1;
          if (bcnt_q == BASE_LAST) begin
            bcnt_q  <= '0;
            state_q <= S_CNT;
          end
        end
        S_CNT: if (acc) begin
          n_q    <= n_d;
          bcnt_q <= bcnt_q + 2'd1;
          if (bcnt_q == CNT_LAST) begin
            bcnt_q  <= '0;
            state_q <= (n_d == 16'd0) ? S_CHK : S_DLO;
          end
        end
        S_DLO: if (acc) begin
          lo_q    <= In_Data;
          chk_q   <= chk_q ^ In_Data;
          state_q <= S_DHI;
        end
        S_DHI: if (acc) begin
          chk_q   <= chk_q ^ In_Data;
          op_q    <= {In_Data, lo_q};
          addr_q  <= ADDR_W'(base_q) + ADDR_W'(idx_q);
          state_q <= S_WSTB;
        end
        S_WSTB: begin
          idx_q   <= idx_q + 16'd1;
          state_q <= (16'(idx_q + 16'd1) == n_q) ? S_CHK : S_DLO;
        end
        S_CHK: if (acc) begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
          if (In_Data == chk_q) done_q <= 1'b1;
          else                  err_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign OP_Code       = op_q;
  assign Write_Address = addr_q;
  assign Write_Enable  = we_q;
  assign Busy          = busy_q;
  assign Done          = done_q;
  assign Error         = err_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: write scoreboard, strobe/handshake monitor, frame scenarios.
module tb_inst_mem_loader;

  logic        Clk, Rst_n;
  logic [7:0]  In_Data;
  logic        In_Valid, In_Ready;
  logic [15:0] OP_Code;
  logic [31:0] Write_Address;
  logic        Write_Enable, Busy, Done, Error;

  int n_chk = 0;
  int n_err = 0;
  int n_done = 0;
  logic [47:0] exp_q[$];
  logic [7:0]  fr[$];

  inst_mem_loader dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Data(In_Data), .In_Valid(In_Valid), .In_Ready(In_Ready),
    .OP_Code(OP_Code), .Write_Address(Write_Address), .Write_Enable(Write_Enable),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: write scoreboard, strobe width, output stability, In_Ready vs strobe.
  logic        prev_rdy = 1'b1, prev_we = 1'b0;
  logic [15:0] prev_op = '0;
  logic [31:0] prev_addr = '0;
  always @(negedge Clk) begin
    if (Rst_n) begin
      check("rdy_we", Write_Enable, !prev_rdy);
      check("done_err", Done & Error, 1'b0);
      if (Write_Enable) begin
        check("we_width", prev_we, 1'b0);
        check("op_before", OP_Code, prev_op);
        check("addr_before", Write_Address, prev_addr);
        if (exp_q.size() == 0) check("we_unexp", 1'b1, 1'b0);
        else check("wr", {Write_Address, OP_Code}, exp_q.pop_front());
      end
      if (prev_we) begin
        check("op_after", OP_Code, prev_op);
        check("addr_after", Write_Address, prev_addr);
      end
      if (Done) n_done++;
    end
    prev_rdy  = In_Ready;
    prev_we   = Write_Enable;
    prev_op   = OP_Code;
    prev_addr = Write_Address;
  end

  task automatic send(input logic [7:0] b, input int gap);
    int tmo;
    In_Valid = 1'b0;
    repeat (gap) @(negedge Clk);
    In_Data  = b;
    In_Valid = 1'b1;
    tmo = 0;
    while (!In_Ready && tmo < 20) begin
      @(negedge Clk);
      tmo++;
    end
    if (tmo >= 20) check("rdy_tmo", 1'b0, 1'b1);
    @(negedge Clk);
    In_Valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap);
    foreach (fr[i]) send(fr[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  initial begin
    int d0;
    Rst_n = 1'b0; In_Valid = 1'b0; In_Data = 8'h00;
    repeat (2) @(negedge Clk);
    check("rst_op", OP_Code, 16'h0);
    check("rst_addr", Write_Address, 32'h0);
    check("rst_we", Write_Enable, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    check("rst_err", Error, 1'b0);
    check("rst_rdy", In_Ready, 1'b1);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Good two-word frame
    exp_q.push_back({32'h0000_0100, 16'h1234});
    exp_q.push_back({32'h0000_0101, 16'hABCD});
    d0 = n_done;
    send(8'hA5, 0);
    check("a_busy_sync", Busy, 1'b1);
    fr = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h40};
    send_frame(0);
    check("a_done", Done, 1'b1);
    check("a_busy", Busy, 1'b0);
    check("a_err", Error, 1'b0);
    @(negedge Clk);
    check("a_done_cnt", n_done - d0, 1);
    check("a_sb", exp_q.size(), 0);

    // Bad checksum: words still land, Error sticky, no Done
    exp_q.push_back({32'h0000_0100, 16'h1234});
    exp_q.push_back({32'h0000_0101, 16'hABCD});
    d0 = n_done;
    fr = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'h41};
    send_frame(0);
    check("b_err", Error, 1'b1);
    check("b_busy", Busy, 1'b0);
    repeat (3) @(negedge Clk);
    check("b_err_sticky", Error, 1'b1);
    check("b_no_done", n_done - d0, 0);

    // Junk ignored, SYNC clears Error, N=0 frame gives Done with no writes
    fr = '{8'h00, 8'hFF, 8'h5A};
    send_frame(0);
    check("c_junk_err", Error, 1'b1);
    check("c_junk_busy", Busy, 1'b0);
    send(8'hA5, 0);
    check("c_err_clr", Error, 1'b0);
    fr = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    check("c_done", Done, 1'b1);
    check("c_busy", Busy, 1'b0);

    // Address wrap
    exp_q.push_back({32'hFFFF_FFFF, 16'h2211});
    exp_q.push_back({32'h0000_0000, 16'h4433});
    fr = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    send_frame(0);
    check("d_done", Done, 1'b1);
    check("d_sb", exp_q.size(), 0);

    // Random gaps, SYNC value inside data
    exp_q.push_back({32'h0001_2340, 16'hA5A5});
    exp_q.push_back({32'h0001_2341, 16'h0F0E});
    exp_q.push_back({32'h0001_2342, 16'h8001});
    fr = '{8'hA5, 8'h40, 8'h23, 8'h01, 8'h00, 8'h03, 8'h00,
           8'hA5, 8'hA5, 8'h0E, 8'h0F, 8'h01, 8'h80, 8'h80};
    send_frame(5);
    check("e_done", Done, 1'b1);
    check("e_err", Error, 1'b0);
    check("e_sb", exp_q.size(), 0);

    // Reset mid-frame after the first word of three
    exp_q.push_back({32'h0000_0200, 16'h1234});
    fr = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h03, 8'h00, 8'h34, 8'h12, 8'h78};
    send_frame(0);
    check("f_busy_mid", Busy, 1'b1);
    #2 Rst_n = 1'b0;
    #1;
    check("f_rst_op", OP_Code, 16'h0);
    check("f_rst_addr", Write_Address, 32'h0);
    check("f_rst_we", Write_Enable, 1'b0);
    check("f_rst_busy", Busy, 1'b0);
    check("f_rst_err", Error, 1'b0);
    check("f_sb", exp_q.size(), 0);
    @(negedge Clk);
    #2 Rst_n = 1'b1;
    @(negedge Clk);
    exp_q.push_back({32'h0000_0300, 16'h5678});
    fr = '{8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h2E};
    send_frame(0);
    check("g_done", Done, 1'b1);
    check("g_err", Error, 1'b0);
    repeat (3) @(negedge Clk);
    check("end_sb", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
